add_issue_ctrl: RTL and testbench
=================================

// Module: add_issue_ctrl
// PURPOSE
//  Upstream issue stage for the gated 4-bit adder register stage test1(x,y,s,clk,r).
//  Buffers operand pairs from a valid/ready source in a small FIFO and drives x/y/s so that
//  s (the load enable the clock-gating flow converts into a gated clock) pulses only on real work.
//  Tracks the downstream 1-cycle latency and presents r as a valid/ready result.
//  Holds s low while idle or while a result is unconsumed, so the downstream register is never clocked needlessly.
// PARAMETERS
//  DATA_W  4  operand/result width; sum is modulo 2**DATA_W, no carry out
//  DEPTH   4  operand FIFO entries; power of 2, >=2
//  AW      $clog2(DEPTH)  localparam, FIFO pointer width
// PORTS
//  clk        in   1       single clock; all state on posedge
//  rst        in   1       synchronous, active-high reset
//  in_valid   in   1       operand pair valid
//  in_ready   out  1       FIFO can accept; = !full && !rst
//  in_x       in   DATA_W  operand A
//  in_y       in   DATA_W  operand B
//  x          out  DATA_W  to downstream x; FIFO head
//  y          out  DATA_W  to downstream y; FIFO head
//  s          out  1       to downstream s; load-enable / gating request
//  r          in   DATA_W  from downstream r (registered x+y)
//  res_valid  out  1       r holds an unconsumed sum
//  res_data   out  DATA_W  = r, meaningful only while res_valid
//  res_ready  in   1       consumer accepts result
//  occupancy  out  AW+1    FIFO entry count
//  idle       out  1       FIFO empty && !res_valid; gating hint to top level
// BEHAVIOUR
//  Reset (rst=1 at posedge): FIFO flushed, occupancy=0, res_valid=0, s=0, idle=1; in_ready=0 while rst high.
//  Push: in_valid && in_ready at posedge writes {in_x,in_y} at tail.
//  Issue: s = !empty && (!res_valid || res_ready). Combinational, low during rst.
//  On s at posedge: pop head; downstream loads r<=x+y; res_valid<=1.
//  Accept without issue (res_valid && res_ready && !s): res_valid<=0.
//  Accept with issue in the same cycle: res_valid stays 1; r replaced with the new sum.
//  Stall: res_valid && !res_ready keeps s=0, so r holds the value.
//  Latency: pushed at edge k -> s high in cycle k+1 (no bypass, empty FIFO) -> res_valid in cycle k+2.
//  Throughput: 1 result per cycle while FIFO non-empty and res_ready=1.
//  x/y driven from head even when s=0; don't-care when empty, but stable (no X) after reset.
//  Full: in_ready=0 even if a pop occurs in the same cycle (no push-on-pop when full).
//  Empty: s=0; if a result is pending, it remains presented.
//  Pointers wrap modulo DEPTH; occupancy in 0..DEPTH; simultaneous push and pop leaves occupancy unchanged.
//  Reset mid-operation: queued operands and pending result are dropped. The downstream r is not reset (it has no reset),
//  and res_valid=0 masks it.
//  States (result slot): EMPTY(res_valid=0) -s-> FULL; FULL -accept&!s-> EMPTY; FULL -accept&s-> FULL;
//  FULL -!accept-> FULL.
// STRUCTURE
//  Package add_issue_pkg: DATA_W default, operand-pair struct/width constant {x,y}.
//  Sub-module sync_fifo #(WIDTH=2*DATA_W, DEPTH): sync reset, push/pop, full/empty/count, head read combinational.
//  Top: FIFO + result-slot register + issue logic; no gating cells instantiated here.
// TESTING (bench instantiates add_issue_ctrl + test1, clk period 10)
//  Reset: rst=1 two cycles -> s=0, res_valid=0, occupancy=0, idle=1, in_ready=0; after release in_ready=1.
//  Single op: push (1,1), res_ready=1 -> s one-cycle pulse at k+1, res_valid at k+2 with res_data=2, idle returns to 1.
//  Back-to-back: push (1,3),(1,2),(4,3) in consecutive cycles, res_ready=1 -> results 4,3,7 on consecutive cycles; s high 3 cycles.
//  Backpressure: res_ready=0, push 5 pairs (9,9)... -> first result 2 (9+9 mod 16) held, s=0, occupancy=4, in_ready=0;
//  raise res_ready -> 4 sums drain in order, no loss or duplication.
//  Wrap/overflow: push (15,1),(8,8),(15,15) -> results 0,0,14; 10 more pushes exercise pointer wrap, order preserved.
//  Reset mid-operation: with occupancy=3 and res_valid=1, pulse rst -> next cycle occupancy=0, res_valid=0, s=0;
//  a new push (2,2) yields 4.

Source files
------------

// File: rtl/add_issue_pkg.sv
// Shared constants and types for the adder issue stage: default widths,
// the {x,y} operand pair and the result-slot state encoding.
package add_issue_pkg;

    localparam int DEFAULT_DATA_W = 4;
    localparam int DEFAULT_DEPTH  = 4;

    typedef struct packed {
        logic [DEFAULT_DATA_W-1:0] x;
        logic [DEFAULT_DATA_W-1:0] y;
    } operand_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    function automatic int pair_width(input int dataW);
        return 2 * dataW;
    endfunction

endpackage

// File: rtl/add_issue_ctrl_fifo.sv
// Small synchronous FIFO with a combinational head read; storage is cleared on
// reset so the head is never X, even when the FIFO is empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q, wrPtr_d;
    logic [AW-1:0]    rdPtr_q, rdPtr_d;
    logic [AW:0]      count_q, count_d;
    logic             doPush, doPop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rdPtr_q];
    assign count_o = count_q;

    // Pushing into a full FIFO is refused even if a pop happens in the same cycle.
    assign doPush = push_i && !full_o;
    assign doPop  = pop_i && !empty_o;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) wrPtr_d = wrPtr_q + AW'(1);
        if (doPop)  rdPtr_d = rdPtr_q + AW'(1);
        case ({doPush, doPop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            if (doPush) mem_q[wrPtr_q] <= data_i;
        end
    end

endmodule

// File: rtl/add_issue_ctrl.sv
// Issue stage for the gated adder register: queues operand pairs and raises s
// only when there is work and the result slot can take a new sum.
module add_issue_ctrl
    import add_issue_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    input  logic [DATA_W-1:0] in_y,
    output logic [DATA_W-1:0] x,
    output logic [DATA_W-1:0] y,
    output logic              s,
    input  logic [DATA_W-1:0] r,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    input  logic              res_ready,
    output logic [AW:0]       occupancy,
    output logic              idle
);

    localparam int PAIR_W = pair_width(DATA_W);

    logic [PAIR_W-1:0] headPair;
    logic              fifoFull, fifoEmpty;
    slot_state_e       slotState_q;

    sync_fifo #(
        .WIDTH(PAIR_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (in_valid && in_ready),
        .data_i  ({in_x, in_y}),
        .pop_i   (s),
        .head_o  (headPair),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (occupancy)
    );

    assign in_ready = !fifoFull && !rst;
    assign x        = headPair[PAIR_W-1:DATA_W];
    assign y        = headPair[DATA_W-1:0];

    // s doubles as the downstream clock-gate request, so it only rises when a sum can land.
    assign s = !fifoEmpty && (slotState_q == SLOT_EMPTY || res_ready) && !rst;

    assign res_valid = (slotState_q == SLOT_FULL);
    assign res_data  = r;
    assign idle      = fifoEmpty && !res_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            slotState_q <= SLOT_EMPTY;
        end else begin
            case (slotState_q)
                SLOT_EMPTY: if (s) slotState_q <= SLOT_FULL;
                SLOT_FULL:  if (!s && res_ready) slotState_q <= SLOT_EMPTY;
                default:    slotState_q <= SLOT_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_add_issue_ctrl.sv
// Bench for add_issue_ctrl with a behavioural stand-in for the downstream test1
// register; a negedge monitor scores every accepted result against a sum queue.
module tb_add_issue_ctrl;

    localparam int DATA_W = 4;
    localparam int DEPTH  = 4;
    localparam int AW     = $clog2(DEPTH);

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_x, in_y;
    logic [DATA_W-1:0] x, y;
    logic              s;
    logic [DATA_W-1:0] r;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic              res_ready;
    logic [AW:0]       occupancy;
    logic              idle;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [DATA_W-1:0] sumQ [$];
    int                modelFifo = 0;
    bit                modelSlot = 0;
    bit                expS, expReady, doPush;
    logic [DATA_W-1:0] expSum;
    int                sHighCount = 0;
    int                resValidCount = 0;

    add_issue_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .x         (x),
        .y         (y),
        .s         (s),
        .r         (r),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready),
        .occupancy (occupancy),
        .idle      (idle)
    );

    // Downstream adder register: loads x+y only on s, and has no reset.
    always @(posedge clk) begin
        if (s) r <= x + y;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: items waiting in the queue, one result slot, sums in arrival order.
    always @(negedge clk) begin
        if (s)         sHighCount++;
        if (res_valid) resValidCount++;
        if (rst) begin
            checkOutput("rst_s", s, 0);
            checkOutput("rst_in_ready", in_ready, 0);
            modelFifo = 0;
            modelSlot = 0;
            sumQ.delete();
        end else begin
            expReady = (modelFifo < DEPTH);
            expS     = (modelFifo > 0) && (!modelSlot || res_ready);
            checkOutput("occupancy", occupancy, modelFifo);
            checkOutput("res_valid", res_valid, modelSlot);
            checkOutput("in_ready", in_ready, expReady);
            checkOutput("s", s, expS);
            checkOutput("idle", idle, (modelFifo == 0 && !modelSlot));
            if (modelSlot && res_ready) begin
                if (sumQ.size() == 0) begin
                    checkOutput("scoreboard_underflow", 1, 0);
                end else begin
                    expSum = sumQ.pop_front();
                    checkOutput("res_data", res_data, expSum);
                end
            end
            doPush = in_valid && expReady;
            if (doPush) begin
                expSum = in_x + in_y;
                sumQ.push_back(expSum);
            end
            modelFifo = modelFifo + int'(doPush) - int'(expS);
            if (expS)           modelSlot = 1'b1;
            else if (res_ready) modelSlot = 1'b0;
        end
    end

    task automatic toDrivePoint();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        int waitCycles = 0;
        in_valid = 1'b1;
        in_x     = a;
        in_y     = b;
        @(negedge clk);
        while (!in_ready && waitCycles < 200) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!in_ready) checkOutput("push_timeout", 0, 1);
        toDrivePoint();
        in_valid = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        res_ready = 1'b1;
        in_valid  = 1'b0;
        while (!(idle && sumQ.size() == 0) && n < limit) begin
            toDrivePoint();
            n++;
        end
        checkOutput("drain_idle", idle, 1);
        checkOutput("drain_queue_left", sumQ.size(), 0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_x      = '0;
        in_y      = '0;
        res_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_s", s, 0);
        checkOutput("reset_res_valid", res_valid, 0);
        checkOutput("reset_occupancy", occupancy, 0);
        checkOutput("reset_idle", idle, 1);
        checkOutput("reset_in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        checkOutput("release_in_ready", in_ready, 1);

        // Single operation: s pulses one cycle after the push, result one cycle later.
        res_ready = 1'b1;
        applyStimulus(4'd1, 4'd1);
        @(negedge clk);
        checkOutput("single_s_pulse", s, 1);
        @(negedge clk);
        checkOutput("single_s_low", s, 0);
        checkOutput("single_res_valid", res_valid, 1);
        checkOutput("single_res_data", res_data, 2);
        @(negedge clk);
        checkOutput("single_idle", idle, 1);
        toDrivePoint();

        sHighCount    = 0;
        resValidCount = 0;
        applyStimulus(4'd1, 4'd3);
        applyStimulus(4'd1, 4'd2);
        applyStimulus(4'd4, 4'd3);
        drain(20);
        checkOutput("b2b_s_cycles", sHighCount, 3);
        checkOutput("b2b_result_cycles", resValidCount, 3);

        // Backpressure: one sum held in the slot, four pairs queued behind it.
        res_ready = 1'b0;
        applyStimulus(4'd9, 4'd9);
        applyStimulus(4'd1, 4'd2);
        applyStimulus(4'd3, 4'd4);
        applyStimulus(4'd5, 4'd6);
        applyStimulus(4'd7, 4'd8);
        @(negedge clk);
        checkOutput("bp_res_valid", res_valid, 1);
        checkOutput("bp_res_data", res_data, 2);
        checkOutput("bp_s", s, 0);
        checkOutput("bp_occupancy", occupancy, 4);
        checkOutput("bp_in_ready", in_ready, 0);
        repeat (3) begin
            @(negedge clk);
            checkOutput("bp_hold_data", res_data, 2);
        end
        toDrivePoint();
        drain(30);

        res_ready = 1'b1;
        applyStimulus(4'd15, 4'd1);
        applyStimulus(4'd8, 4'd8);
        applyStimulus(4'd15, 4'd15);
        for (int i = 0; i < 10; i++) applyStimulus(4'($urandom), 4'($urandom));
        drain(30);

        // Reset mid-operation drops both queued pairs and the pending result.
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(4'(i + 3), 4'(i));
        @(negedge clk);
        checkOutput("mid_occupancy_before", occupancy, 3);
        checkOutput("mid_res_valid_before", res_valid, 1);
        toDrivePoint();
        rst = 1'b1;
        toDrivePoint();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("mid_occupancy_after", occupancy, 0);
        checkOutput("mid_res_valid_after", res_valid, 0);
        checkOutput("mid_s_after", s, 0);
        toDrivePoint();
        res_ready = 1'b1;
        applyStimulus(4'd2, 4'd2);
        @(negedge clk);
        @(negedge clk);
        checkOutput("mid_new_res_valid", res_valid, 1);
        checkOutput("mid_new_res_data", res_data, 4);
        toDrivePoint();
        drain(20);

        for (int cyc = 0; cyc < 400; cyc++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_x      = 4'($urandom);
            in_y      = 4'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            toDrivePoint();
        end
        drain(40);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #200000;
        testsFailed++;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
